// File: rtl/mem_stage_pkg.sv
// Shared bus widths, EX-to-MEM field offsets and the load-width encoding
// used by the MEM stage and its load-alignment helper.
package mycpu_pkg;

    localparam int EX_TO_MEM_W = 251;
    localparam int MEM_TO_WB_W = 251;
    localparam int MEM_TO_ID_W = 40;
    localparam int MEM_TO_EX_W = 3;

    localparam int F_PC_LSB        = 219;
    localparam int F_RES_FROM_MEM  = 218;
    localparam int F_RF_WE         = 217;
    localparam int F_RF_WADDR_LSB  = 212;
    localparam int F_ALU_RES_LSB   = 180;
    localparam int F_ADDR_LSB      = 146;
    localparam int F_LD_B          = 145;
    localparam int F_LD_H          = 144;
    localparam int F_LD_U          = 143;
    localparam int F_READ_CNT      = 142;
    localparam int F_CNT_RES_LSB   = 110;
    localparam int F_CSR_RE        = 108;
    localparam int F_ERTN_FLUSH    = 60;
    localparam int F_EXCEP_EN      = 59;
    localparam int F_MEM_REQ       = 11;
    localparam int F_SRCH_CONFLICT = 5;

    typedef enum logic [1:0] {
        LD_WORD = 2'd0,
        LD_HALF = 2'd1,
        LD_BYTE = 2'd2
    } ld_width_e;

    function automatic ld_width_e ld_width(input logic ld_b, input logic ld_h);
        if (ld_b) begin
            return LD_BYTE;
        end
        if (ld_h) begin
            return LD_HALF;
        end
        return LD_WORD;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/SRAM/WB-facing signal bundle of the MEM stage; the stage itself
// connects through the slave modport, its environment through master.
interface mem_stage_if;
    import mycpu_pkg::*;

    logic                   ex_to_mem_valid;
    logic                   mem_allowin;
    logic [EX_TO_MEM_W-1:0] ex_to_mem_bus;
    logic                   data_sram_data_ok;
    logic [31:0]            data_sram_rdata;
    logic                   wb_allowin;
    logic                   mem_to_wb_valid;
    logic [MEM_TO_WB_W-1:0] mem_to_wb_bus;
    logic [MEM_TO_ID_W-1:0] mem_to_id_bus;
    logic [MEM_TO_EX_W-1:0] mem_to_ex_bus;
    logic                   flush;

    modport slave (
        input  ex_to_mem_valid, ex_to_mem_bus, data_sram_data_ok,
               data_sram_rdata, wb_allowin, flush,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               mem_to_id_bus, mem_to_ex_bus
    );

    modport master (
        output ex_to_mem_valid, ex_to_mem_bus, data_sram_data_ok,
               data_sram_rdata, wb_allowin, flush,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               mem_to_id_bus, mem_to_ex_bus
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/half of the SRAM
// word and sign- or zero-extends it; word loads pass straight through.
module load_align
    import mycpu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic        ld_b_i,
    input  logic        ld_h_i,
    input  logic        ld_u_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_i)
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            2'd3:    byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        data_o = rdata_i;
        case (ld_width(ld_b_i, ld_h_i))
            LD_BYTE: data_o = {{24{byte_sel[7] & ~ld_u_i}}, byte_sel};
            LD_HALF: data_o = {{16{half_sel[15] & ~ld_u_i}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: holds one instruction, waits for its data-SRAM response, aligns
// load data and drops responses of flushed requests. MEM_LOAD_BYPASS_EN lets ID forward load data in the data_ok cycle.
module mem_stage
    import mycpu_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave mem_if
);

    logic                   mem_valid_q, mem_valid_d;
    logic [EX_TO_MEM_W-1:0] bus_q, bus_d;
    logic                   resp_got_q, resp_got_d;
    logic [31:0]            resp_data_q, resp_data_d;
    logic [1:0]             discard_cnt_q, discard_cnt_d;

    logic        mem_req;
    logic        data_ok_acc;
    logic        ready_go;
    logic        allowin;
    logic        leave;
    logic        accept;
    logic        inc_hold;
    logic        inc_enter;
    logic        dec;
    logic [2:0]  cnt_sum;
    logic [31:0] load_raw;
    logic [31:0] load_data;
    logic [31:0] final_data;
    logic        load_stall;

    assign mem_req     = bus_q[F_MEM_REQ];
    // Responses arriving while cancelled requests are outstanding belong to them.
    assign data_ok_acc = mem_if.data_sram_data_ok & (discard_cnt_q == 2'd0);
    assign ready_go    = ~mem_req | resp_got_q | data_ok_acc;
    assign allowin     = ~mem_valid_q | (ready_go & mem_if.wb_allowin);
    assign leave       = mem_valid_q & ready_go & mem_if.wb_allowin;
    assign accept      = mem_if.ex_to_mem_valid & allowin;

    always_comb begin
        mem_valid_d = mem_valid_q;
        if (mem_if.flush) begin
            mem_valid_d = 1'b0;
        end else if (allowin) begin
            mem_valid_d = mem_if.ex_to_mem_valid;
        end

        bus_d = accept ? mem_if.ex_to_mem_bus : bus_q;

        resp_got_d  = resp_got_q;
        resp_data_d = resp_data_q;
        if (mem_if.flush | leave) begin
            resp_got_d  = 1'b0;
            resp_data_d = 32'd0;
        end else if (mem_valid_q & mem_req & ~resp_got_q & data_ok_acc) begin
            resp_got_d  = 1'b1;
            resp_data_d = mem_if.data_sram_rdata;
        end
    end

    // A flushed request whose response is still in flight, either the one held
    // here or the one entering right now, must have that response swallowed.
    always_comb begin
        inc_hold  = mem_if.flush & mem_valid_q & mem_req & ~resp_got_q & ~data_ok_acc;
        inc_enter = mem_if.flush & accept & mem_if.ex_to_mem_bus[F_MEM_REQ];
        dec       = mem_if.data_sram_data_ok & (discard_cnt_q != 2'd0);
        cnt_sum   = {1'b0, discard_cnt_q} + {2'b00, inc_hold} + {2'b00, inc_enter}
                    - {2'b00, dec};
        discard_cnt_d = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
    end

    assign load_raw = resp_got_q ? resp_data_q : mem_if.data_sram_rdata;

    load_align u_load_align (
        .rdata_i (load_raw),
        .addr_i  (bus_q[F_ADDR_LSB +: 2]),
        .ld_b_i  (bus_q[F_LD_B]),
        .ld_h_i  (bus_q[F_LD_H]),
        .ld_u_i  (bus_q[F_LD_U]),
        .data_o  (load_data)
    );

    always_comb begin
        final_data = bus_q[F_ALU_RES_LSB +: 32];
        if (bus_q[F_RES_FROM_MEM]) begin
            final_data = load_data;
        end else if (bus_q[F_READ_CNT]) begin
            final_data = bus_q[F_CNT_RES_LSB +: 32];
        end
    end

`ifdef MEM_LOAD_BYPASS_EN
    assign load_stall = mem_valid_q & bus_q[F_RES_FROM_MEM] & ~ready_go;
`else
    assign load_stall = mem_valid_q & bus_q[F_RES_FROM_MEM];
`endif

    assign mem_if.mem_allowin     = allowin;
    assign mem_if.mem_to_wb_valid = mem_valid_q & ready_go;
    assign mem_if.mem_to_wb_bus   = {bus_q[EX_TO_MEM_W-1:F_ALU_RES_LSB+32], final_data,
                                     bus_q[F_ALU_RES_LSB-1:0]};
    assign mem_if.mem_to_id_bus   = {bus_q[F_RF_WE] & mem_valid_q,
                                     bus_q[F_RF_WADDR_LSB +: 5],
                                     final_data,
                                     bus_q[F_CSR_RE] & mem_valid_q,
                                     load_stall};
    assign mem_if.mem_to_ex_bus   = {bus_q[F_EXCEP_EN] & mem_valid_q,
                                     bus_q[F_ERTN_FLUSH] & mem_valid_q,
                                     bus_q[F_SRCH_CONFLICT] & mem_valid_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q   <= 1'b0;
            bus_q         <= '0;
            resp_got_q    <= 1'b0;
            resp_data_q   <= 32'd0;
            discard_cnt_q <= 2'd0;
        end else begin
            mem_valid_q   <= mem_valid_d;
            bus_q         <= bus_d;
            resp_got_q    <= resp_got_d;
            resp_data_q   <= resp_data_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: an in-order SRAM model feeds
// responses, a reference model predicts every WB handoff and side-bus value.
module tb_mem_stage;
    import mycpu_pkg::*;

    localparam int NCYC     = 4000;
    localparam int MAX_DRAIN = 300;

    typedef struct {
        logic [250:0] bus;
        logic [31:0]  rdata;
    } instr_t;

    typedef struct {
        logic [31:0] rdata;
        int          id;
    } pend_t;

    typedef struct {
        logic [250:0] exp_bus;
        int           id;
        bit           mem_req;
        bit           got;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if mif ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .mem_if (mif.slave)
    );

    int     checks = 0;
    int     errors = 0;
    exp_t   sb_q[$];
    pend_t  sram_q[$];
    instr_t dir_q[$];
    logic [250:0] last_bus = '0;
    bit     mon_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the load rules: shift the word down to
    // the addressed byte/half, then extend according to ld_u.
    function automatic logic [31:0] ref_result(input logic [250:0] b, input logic [31:0] rd);
        int unsigned sh;
        logic [7:0]  by;
        logic [15:0] hw;
        if (b[F_RES_FROM_MEM]) begin
            sh = 32'(b[F_ADDR_LSB +: 2]);
            by = 8'(rd >> (8 * sh));
            hw = 16'(rd >> (16 * (sh / 2)));
            if (b[F_LD_B]) return b[F_LD_U] ? 32'(by) : 32'($signed(by));
            if (b[F_LD_H]) return b[F_LD_U] ? 32'(hw) : 32'($signed(hw));
            return rd;
        end
        if (b[F_READ_CNT]) return b[F_CNT_RES_LSB +: 32];
        return b[F_ALU_RES_LSB +: 32];
    endfunction

    function automatic instr_t gen_rand();
        instr_t       t;
        logic [255:0] raw;
        int           kind;
        int           lw;
        for (int i = 0; i < 8; i++) raw[i*32 +: 32] = $urandom;
        t.bus = raw[250:0];
        kind  = $urandom_range(0, 3);
        lw    = $urandom_range(0, 2);
        t.bus[F_MEM_REQ]      = (kind == 1) || (kind == 2);
        t.bus[F_RES_FROM_MEM] = (kind == 2);
        t.bus[F_READ_CNT]     = (kind == 3);
        t.bus[F_LD_B]         = (lw == 2);
        t.bus[F_LD_H]         = (lw == 1);
        t.rdata = $urandom;
        return t;
    endfunction

    function automatic instr_t mk(input bit is_load, input logic [1:0] addr, input bit b,
                                  input bit h, input bit u, input logic [31:0] alu,
                                  input logic [31:0] rd, input logic [2:0] exc);
        instr_t t;
        t.bus = '0;
        t.bus[F_PC_LSB +: 32]        = 32'h1c00_0000 + 32'($urandom_range(0, 255) * 4);
        t.bus[F_RF_WE]               = 1'b1;
        t.bus[F_RF_WADDR_LSB +: 5]   = 5'd7;
        t.bus[F_RES_FROM_MEM]        = is_load;
        t.bus[F_MEM_REQ]             = is_load;
        t.bus[F_ADDR_LSB +: 2]       = addr;
        t.bus[F_LD_B]                = b;
        t.bus[F_LD_H]                = h;
        t.bus[F_LD_U]                = u;
        t.bus[F_ALU_RES_LSB +: 32]   = alu;
        t.bus[F_EXCEP_EN]            = exc[2];
        t.bus[F_ERTN_FLUSH]          = exc[1];
        t.bus[F_SRCH_CONFLICT]       = exc[0];
        t.rdata = rd;
        return t;
    endfunction

    // Monitor: predicts this cycle's outputs from the model and pops on handoff.
    exp_t       h;
    bit         have;
    bit         avail;
    bit         now_ok;
    bit         exp_stall;
    logic [2:0] exp_ex;
    always @(negedge clk) begin
        if (mon_en) begin
            have = (sb_q.size() > 0);
            if (have) h = sb_q[0];
            now_ok = have && mif.data_sram_data_ok && (sram_q.size() > 0) && (sram_q[0].id == h.id);
            avail  = have && (!h.mem_req || h.got || now_ok);
            chk("wb_valid", mif.mem_to_wb_valid, avail);
            chk("allowin", mif.mem_allowin, !have || (avail && mif.wb_allowin));
            if (avail && mif.mem_to_wb_valid && mif.wb_allowin) begin
                chk("wb_bus", mif.mem_to_wb_bus, h.exp_bus);
                void'(sb_q.pop_front());
            end
            exp_ex = have ? {h.exp_bus[F_EXCEP_EN], h.exp_bus[F_ERTN_FLUSH],
                             h.exp_bus[F_SRCH_CONFLICT]} : 3'b000;
            chk("ex_bus", mif.mem_to_ex_bus, exp_ex);
            chk("id_rf_we", mif.mem_to_id_bus[39], have && h.exp_bus[F_RF_WE]);
            chk("id_waddr", mif.mem_to_id_bus[38:34], last_bus[F_RF_WADDR_LSB +: 5]);
            chk("id_csr_re", mif.mem_to_id_bus[1], have && h.exp_bus[F_CSR_RE]);
`ifdef MEM_LOAD_BYPASS_EN
            exp_stall = have && h.exp_bus[F_RES_FROM_MEM] && !avail;
`else
            exp_stall = have && h.exp_bus[F_RES_FROM_MEM];
`endif
            chk("load_stall", mif.mem_to_id_bus[0], exp_stall);
            if (avail) chk("id_wdata", mif.mem_to_id_bus[33:2], h.exp_bus[F_ALU_RES_LSB +: 32]);
        end
    end

    // Stimulus and bookkeeping.
    instr_t offer;
    bit     offer_valid = 1'b0;
    int     id_ctr = 0;
    initial begin
        bit           drain;
        pend_t        p;
        logic [250:0] eb;
        int           cyc;

        mif.ex_to_mem_valid   = 1'b0;
        mif.ex_to_mem_bus     = '0;
        mif.data_sram_data_ok = 1'b0;
        mif.data_sram_rdata   = 32'd0;
        mif.wb_allowin        = 1'b1;
        mif.flush             = 1'b0;

        dir_q.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 32'h0, 32'h80FF_1234, 3'b000));
        dir_q.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 32'h0, 32'h8001_0000, 3'b000));
        dir_q.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 3'b101));
        dir_q.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_A500, 3'b010));

        @(negedge clk);
        chk("rst_allowin", mif.mem_allowin, 1'b1);
        chk("rst_wb_valid", mif.mem_to_wb_valid, 1'b0);
        chk("rst_id_bus", mif.mem_to_id_bus, '0);
        chk("rst_ex_bus", mif.mem_to_ex_bus, '0);
        chk("rst_wb_bus", mif.mem_to_wb_bus, '0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        mon_en = 1'b1;

        cyc = 0;
        while (cyc < NCYC + MAX_DRAIN) begin
            drain = (cyc >= NCYC);
            if (drain && sb_q.size() == 0 && sram_q.size() == 0) break;

            if (!offer_valid && !drain) begin
                if (dir_q.size() > 0) begin
                    offer = dir_q.pop_front();
                    offer_valid = 1'b1;
                end else if ($urandom_range(0, 9) < 7) begin
                    offer = gen_rand();
                    offer_valid = 1'b1;
                end
            end
            mif.ex_to_mem_valid = offer_valid && !drain &&
                                  !(offer.bus[F_MEM_REQ] && sram_q.size() >= 3);
            mif.ex_to_mem_bus   = offer.bus;
            mif.wb_allowin      = drain ? 1'b1 : ($urandom_range(0, 9) < 7);
            mif.flush           = !drain && (cyc >= 30) && ($urandom_range(0, 24) == 0);
            if (sram_q.size() > 0 && (drain || $urandom_range(0, 1) == 1)) begin
                mif.data_sram_data_ok = 1'b1;
                mif.data_sram_rdata   = sram_q[0].rdata;
            end else begin
                mif.data_sram_data_ok = 1'b0;
                mif.data_sram_rdata   = $urandom;
            end

            @(negedge clk);
            #1;
            if (mif.data_sram_data_ok) begin
                p = sram_q.pop_front();
                if (sb_q.size() > 0 && sb_q[0].id == p.id) sb_q[0].got = 1'b1;
            end
            if (mif.flush) sb_q.delete();
            if (mif.ex_to_mem_valid && mif.mem_allowin) begin
                id_ctr++;
                last_bus = offer.bus;
                if (offer.bus[F_MEM_REQ]) sram_q.push_back('{rdata: offer.rdata, id: id_ctr});
                if (!mif.flush) begin
                    eb = offer.bus;
                    eb[F_ALU_RES_LSB +: 32] = ref_result(offer.bus, offer.rdata);
                    sb_q.push_back('{exp_bus: eb, id: id_ctr,
                                     mem_req: offer.bus[F_MEM_REQ], got: 1'b0});
                end
                offer_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end

        mif.ex_to_mem_valid   = 1'b0;
        mif.data_sram_data_ok = 1'b0;
        mif.flush             = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        chk("drain_sb_empty", 256'(sb_q.size()), 256'd0);
        chk("drain_sram_empty", 256'(sram_q.size()), 256'd0);
        chk("drain_wb_valid", mif.mem_to_wb_valid, 1'b0);
        chk("drain_allowin", mif.mem_allowin, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, placed between the EX stage and WB. It accepts the EX-to-MEM bus, waits for the data-SRAM `data_ok` of any request EX issued, and aligns and extends load data. It forwards the result bus to WB and reports hazard, exception and TLBSRCH-conflict status back to ID and EX. After a WB flush it discards responses to cancelled requests so the SRAM-like interface stays consistent.

## Interface
- No parameters; bus widths and field offsets come from `mycpu_pkg`.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ex_to_mem_valid` in 1: EX has an instruction ready for MEM.
- `mem_allowin` out 1: MEM can accept an instruction this cycle.
- `ex_to_mem_bus` in 251: EX payload; field layout in `mycpu_pkg`, MSB first: pc[250:219], res_from_mem[218], rf_we[217], rf_waddr[216:212], alu_result[211:180], data_sram_addr[147:146], ld_b[145], ld_h[144], ld_u[143], read_counter[142], counter_result[141:110], csr_re[108], ertn_flush[60], excep_en[59], mem_req[11], srch_conflict[5].
- `data_sram_data_ok` in 1: read/write response.
- `data_sram_rdata` in 32: load data, valid with `data_ok`.
- `wb_allowin` in 1: WB can accept.
- `mem_to_wb_valid` out 1: instruction handed to WB.
- `mem_to_wb_bus` out 251: the latched bus, with [211:180] replaced by the final write-back data.
- `mem_to_id_bus` out 40: {rf_we&valid, rf_waddr, wdata, csr_re&valid, load_stall}.
- `mem_to_ex_bus` out 3: {excep_en&valid, ertn_flush&valid, srch_conflict&valid}.
- `flush` in 1: WB exception or ERTN flush.

## Operation
- Pipeline control:
  - mem_ready_go = ~mem_req | resp_got | (data_sram_data_ok & discard_cnt==0).
  - mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
  - mem_to_wb_valid = mem_valid & mem_ready_go.
- mem_valid:
  - cleared by `flush`;
  - otherwise loaded with `ex_to_mem_valid` when mem_allowin.
- Bus register: loaded when ex_to_mem_valid & mem_allowin; a flush does not clear it.
- Response buffer:
  - A `data_ok` accepted while WB stalls sets resp_got and latches rdata into resp_data.
  - Both clear when the instruction leaves MEM or on flush.
- Final data:
  - res_from_mem: the load data, taken from resp_data when resp_got, otherwise from live rdata.
  - read_counter: counter_result.
  - Otherwise: alu_result.
- Load alignment: byte/half selected by data_sram_addr[1:0] and addr[1], then sign-extended, or zero-extended when ld_u; word loads pass through.
- Cancel counter discard_cnt, 2 bits, saturating at 3:
  - Increments on flush when MEM holds mem_req & ~resp_got & ~data_ok.
  - Also increments if EX's request for an instruction entering this cycle was already accepted.
  - Decrements on every data_ok while nonzero; such responses are ignored.
  - If flush and data_ok coincide with count>0, the net count is unchanged.
- load_stall = mem_valid & res_from_mem & ~(mem_ready_go).

## Timing
- Reset values: mem_valid=0, resp_got=0, discard_cnt=0, bus register 0. Consequently mem_to_wb_valid=0, mem_allowin=1, and the id/ex buses are all 0.
- Latency:
  - Non-memory instruction: 1 cycle in MEM.
  - Memory instruction: leaves in the data_ok cycle if wb_allowin, otherwise in the first later cycle with wb_allowin.
- data_ok may arrive in the same cycle the instruction enters MEM's register plus one, never earlier.
- Flush takes effect at the next edge. The stage never asserts mem_to_wb_valid in the cycle after a flush.
- Reset asserted mid-request clears everything immediately; the SRAM side is reset together.

## Configuration
- `MEM_LOAD_BYPASS_EN` defined:
  - In the data_ok cycle, mem_to_id_bus.wdata carries the aligned load data and load_stall is 0, so ID may forward it.
- Undefined:
  - load_stall = mem_valid & res_from_mem for the whole MEM residency, so ID must wait for WB.

## Structure
- `mycpu_pkg`:
  - EX_TO_MEM_W=251, MEM_TO_WB_W=251, MEM_TO_ID_W=40;
  - all field-offset localparams listed above;
  - the load-width encoding.
- Sub-module `load_align`: combinational; inputs rdata, addr[1:0], ld_b, ld_h, ld_u; output 32-bit data.
- The top level holds the valid bit, bus register, response buffer and cancel counter.

## Test plan
- ld.b, addr[1:0]=2'b11, rdata=32'h80FF_1234, ld_u=0, data_ok 2 cycles after entry -> wdata=32'hFFFF_FF80; mem_to_wb_valid in the data_ok cycle.
- ld.hu, addr=2'b10, rdata=32'h8001_0000 -> wdata=32'h0000_8001.
- data_ok while wb_allowin=0 for 3 cycles -> rdata buffered, WB receives the correct data on cycle 4, and no second response is consumed.
- Flush while a load awaits data_ok -> discard_cnt=1; the next data_ok (rdata=32'hDEAD_BEEF) is dropped; the following load's data_ok is used and the count returns to 0.
- Non-memory add with alu_result=32'h1234 -> mem_to_wb_valid one cycle after entry, wdata=32'h1234; mem_to_ex_bus reflects excep_en/ertn_flush/srch_conflict only while valid.
- `MEM_LOAD_BYPASS_EN` on and off -> load_stall drops in the data_ok cycle only when the macro is defined.
